// File: rtl/seq_addsub_alu_pkg.sv
// Shared types for the sequential add/subtract unit: operation codes, FSM states and result flags.
package alu_pkg;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   typedef struct packed {
      logic cb;
      logic ovf;
      logic zero;
   } alu_flags_t;

endpackage

// File: rtl/seq_addsub_alu_if.sv
// Operand/result handshake bundle for seq_addsub_alu; master is the producer/consumer side, slave is the unit.
interface seq_addsub_alu_if #(
   parameter int WIDTH = 16
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_q;
   logic             out_cb;
   logic             out_ovf;
   logic             out_zero;
   logic             busy;

   modport master (
      output in_valid, in_a, in_b, in_op, out_ready,
      input  in_ready, out_valid, out_q, out_cb, out_ovf, out_zero, busy
   );

   modport slave (
      input  in_valid, in_a, in_b, in_op, out_ready,
      output in_ready, out_valid, out_q, out_cb, out_ovf, out_zero, busy
   );

endinterface

// File: rtl/seq_addsub_alu_chunk.sv
// One CHUNK-bit add/subtract slice: b is inverted when subtracting, so a - b = a + ~b + 1 with cin = 1.
module addsub_chunk #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             op,
   input  logic             cin,
   output logic [CHUNK-1:0] q,
   output logic             cout
);

   logic [CHUNK:0] sum;

   assign sum       = {1'b0, a} + {1'b0, b ^ {CHUNK{op}}} + {{CHUNK{1'b0}}, cin};
   assign {cout, q} = sum;

endmodule

// File: rtl/seq_addsub_alu.sv
// Multi-cycle WIDTH-bit add/subtract, one CHUNK-bit slice per clock, LSB first.
// Define SEQ_ADDSUB_SAT_EN to clamp overflowing results to the signed extreme.
module seq_addsub_alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   seq_addsub_alu_if.slave   bus
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam int LSBW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

   state_e           state;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] q_reg;
   op_e              op_reg;
   logic             carry;
   logic [IDXW-1:0]  idx;

   logic [LSBW-1:0]  lsb;
   logic [CHUNK-1:0] slice_a;
   logic [CHUNK-1:0] slice_b;
   logic [CHUNK-1:0] slice_q;
   logic             slice_cout;
   logic [WIDTH-1:0] q_next;
   logic [WIDTH-1:0] q_final;
   alu_flags_t       flags_next;

   assign lsb     = LSBW'(int'(idx) * CHUNK);
   assign slice_a = a_reg[lsb +: CHUNK];
   assign slice_b = b_reg[lsb +: CHUNK];

   addsub_chunk #(
      .CHUNK (CHUNK)
   ) u_chunk (
      .a    (slice_a),
      .b    (slice_b),
      .op   (op_reg),
      .cin  (carry),
      .q    (slice_q),
      .cout (slice_cout)
   );

   // Full result and flags as they would be if this were the last slice; only latched on the final CALC cycle.
   always_comb begin
      q_next             = q_reg;
      q_next[lsb +: CHUNK] = slice_q;
      flags_next.cb      = slice_cout ^ op_reg;
      flags_next.ovf     = (a_reg[WIDTH-1] == (b_reg[WIDTH-1] ^ op_reg)) &&
                           (q_next[WIDTH-1] != a_reg[WIDTH-1]);
`ifdef SEQ_ADDSUB_SAT_EN
      if (flags_next.ovf) begin
         q_final = a_reg[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end else begin
         q_final = q_next;
      end
`else
      q_final = q_next;
`endif
      flags_next.zero    = (q_final == '0);
   end

   // Control FSM; every output is registered so a reset mid-operation never exposes a partial sum.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         a_reg         <= '0;
         b_reg         <= '0;
         q_reg         <= '0;
         op_reg        <= OP_ADD;
         carry         <= 1'b0;
         idx           <= '0;
         bus.in_ready  <= 1'b1;
         bus.out_valid <= 1'b0;
         bus.out_q     <= '0;
         bus.out_cb    <= 1'b0;
         bus.out_ovf   <= 1'b0;
         bus.out_zero  <= 1'b0;
         bus.busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  a_reg        <= bus.in_a;
                  b_reg        <= bus.in_b;
                  op_reg       <= op_e'(bus.in_op);
                  carry        <= bus.in_op;
                  idx          <= '0;
                  bus.in_ready <= 1'b0;
                  bus.busy     <= 1'b1;
                  state        <= CALC;
               end
            end
            CALC: begin
               q_reg <= q_next;
               carry <= slice_cout;
               idx   <= idx + 1'b1;
               if (idx == LAST_IDX) begin
                  idx           <= '0;
                  bus.out_valid <= 1'b1;
                  bus.out_q     <= q_final;
                  bus.out_cb    <= flags_next.cb;
                  bus.out_ovf   <= flags_next.ovf;
                  bus.out_zero  <= flags_next.zero;
                  state         <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  bus.out_valid <= 1'b0;
                  bus.in_ready  <= 1'b1;
                  bus.busy      <= 1'b0;
                  state         <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_addsub_alu.sv
// Drives three seq_addsub_alu instances (CHUNK = 1, 4, 16) with identical operands and checks each one.
module tb_seq_addsub_alu;

   localparam int WIDTH = 16;
   localparam int CH [3] = '{1, 4, 16};
`ifdef SEQ_ADDSUB_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic             in_valid;
   logic             in_op;
   logic             out_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;

   seq_addsub_alu_if #(.WIDTH(WIDTH)) bus1 ();
   seq_addsub_alu_if #(.WIDTH(WIDTH)) bus4 ();
   seq_addsub_alu_if #(.WIDTH(WIDTH)) bus16 ();

   assign {bus16.in_valid, bus4.in_valid, bus1.in_valid}    = {3{in_valid}};
   assign {bus16.in_op, bus4.in_op, bus1.in_op}             = {3{in_op}};
   assign {bus16.out_ready, bus4.out_ready, bus1.out_ready} = {3{out_ready}};
   assign {bus16.in_a, bus4.in_a, bus1.in_a}                = {3{in_a}};
   assign {bus16.in_b, bus4.in_b, bus1.in_b}                = {3{in_b}};

   seq_addsub_alu #(.WIDTH(WIDTH), .CHUNK(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(bus1));
   seq_addsub_alu #(.WIDTH(WIDTH), .CHUNK(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4));
   seq_addsub_alu #(.WIDTH(WIDTH), .CHUNK(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

   logic [2:0]            ov, ir, bz, cb, ovf, zr;
   logic [2:0][WIDTH-1:0] q;
   assign ov  = {bus16.out_valid, bus4.out_valid, bus1.out_valid};
   assign ir  = {bus16.in_ready, bus4.in_ready, bus1.in_ready};
   assign bz  = {bus16.busy, bus4.busy, bus1.busy};
   assign cb  = {bus16.out_cb, bus4.out_cb, bus1.out_cb};
   assign ovf = {bus16.out_ovf, bus4.out_ovf, bus1.out_ovf};
   assign zr  = {bus16.out_zero, bus4.out_zero, bus1.out_zero};
   assign q   = {bus16.out_q, bus4.out_q, bus1.out_q};

   int checks = 0;
   int errors = 0;

   logic [2:0][WIDTH-1:0] rq;
   logic [2:0]            rcb, rovf, rzero;
   int                    rlat [3];

   // Offers one operation, scrambles the inputs after acceptance and captures each unit's result as it appears.
   task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic op);
      logic [2:0] seen;
      int         cnt;
      seen      = '0;
      in_a      = a;
      in_b      = b;
      in_op     = op;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_a     = ~a;
      in_b     = a ^ b;
      in_op    = ~op;
      checks++;
      if (ir !== 3'b000) begin
         errors++;
         $display("[TB] FAIL accept_in_ready: got %b, expected 000", ir);
      end
      checks++;
      if (bz !== 3'b111) begin
         errors++;
         $display("[TB] FAIL accept_busy: got %b, expected 111", bz);
      end
      cnt = 0;
      while (seen != 3'b111 && cnt < 40) begin
         for (int i = 0; i < 3; i++) begin
            if (!seen[i] && ov[i]) begin
               seen[i]  = 1'b1;
               rlat[i]  = cnt;
               rq[i]    = q[i];
               rcb[i]   = cb[i];
               rovf[i]  = ovf[i];
               rzero[i] = zr[i];
            end
         end
         if (seen != 3'b111) begin
            @(posedge clk); #1;
            cnt++;
         end
      end
      checks++;
      if (seen !== 3'b111) begin
         errors++;
         $display("[TB] FAIL result_timeout: got valid mask %b, expected 111", seen);
      end
   endtask

   // Accepts all results for one cycle and checks the units are back in IDLE with outputs retained.
   task automatic retire();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++;
      if (ov !== 3'b000 || ir !== 3'b111 || bz !== 3'b000) begin
         errors++;
         $display("[TB] FAIL retire_idle: got valid %b ready %b busy %b, expected 000 111 000", ov, ir, bz);
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (q[i] !== rq[i]) begin
            errors++;
            $display("[TB] FAIL retire_hold_q chunk=%0d: got %h, expected %h", CH[i], q[i], rq[i]);
         end
      end
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_op     = 1'b0;
      in_a      = '0;
      in_b      = '0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (ov !== 3'b000 || bz !== 3'b000 || cb !== 3'b000 || ovf !== 3'b000 || zr !== 3'b000 || q !== '0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got valid %b busy %b cb %b ovf %b zero %b q %h, expected all zero",
                  ov, bz, cb, ovf, zr, q);
      end
      rst_n = 1'b1;
      #1;
      checks++;
      if (ir !== 3'b111) begin
         errors++;
         $display("[TB] FAIL reset_in_ready: got %b, expected 111", ir);
      end
   endtask

   typedef struct {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             op;
      logic [WIDTH-1:0] q;
      logic             cb;
      logic             ovf;
      logic             zero;
   } vec_t;

   task automatic test_directed();
      vec_t v [8];
      v[0] = '{16'h0005, 16'h0003, 1'b1, 16'h0002, 1'b0, 1'b0, 1'b0};
      v[1] = '{16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b1, 1'b0, 1'b0};
      v[2] = '{16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1};
      v[3] = '{16'h7FFF, 16'h0001, 1'b0, SAT ? 16'h7FFF : 16'h8000, 1'b0, 1'b1, 1'b0};
      v[4] = '{16'h8000, 16'h0001, 1'b1, SAT ? 16'h8000 : 16'h7FFF, 1'b0, 1'b1, 1'b0};
      v[5] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
      v[6] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0};
      v[7] = '{16'h8000, 16'h8000, 1'b0, SAT ? 16'h8000 : 16'h0000, 1'b1, 1'b1, !SAT};
      for (int n = 0; n < 8; n++) begin
         run_op(v[n].a, v[n].b, v[n].op);
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (rq[i] !== v[n].q) begin
               errors++;
               $display("[TB] FAIL dir%0d_q chunk=%0d: got %h, expected %h", n, CH[i], rq[i], v[n].q);
            end
            checks++;
            if (rcb[i] !== v[n].cb) begin
               errors++;
               $display("[TB] FAIL dir%0d_cb chunk=%0d: got %b, expected %b", n, CH[i], rcb[i], v[n].cb);
            end
            checks++;
            if (rovf[i] !== v[n].ovf) begin
               errors++;
               $display("[TB] FAIL dir%0d_ovf chunk=%0d: got %b, expected %b", n, CH[i], rovf[i], v[n].ovf);
            end
            checks++;
            if (rzero[i] !== v[n].zero) begin
               errors++;
               $display("[TB] FAIL dir%0d_zero chunk=%0d: got %b, expected %b", n, CH[i], rzero[i], v[n].zero);
            end
            checks++;
            if (rlat[i] != WIDTH / CH[i]) begin
               errors++;
               $display("[TB] FAIL dir%0d_latency chunk=%0d: got %0d, expected %0d", n, CH[i], rlat[i], WIDTH / CH[i]);
            end
         end
         retire();
      end
   endtask

   task automatic test_backpressure();
      run_op(16'h1234, 16'h4321, 1'b0);
      for (int c = 0; c < 3; c++) begin
         in_valid = c[0] ? 1'b0 : 1'b1;
         in_a     = 16'hAAAA;
         in_b     = 16'h5555;
         @(posedge clk); #1;
         checks++;
         if (ov !== 3'b111 || ir !== 3'b000) begin
            errors++;
            $display("[TB] FAIL hold%0d_handshake: got valid %b ready %b, expected 111 000", c, ov, ir);
         end
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (q[i] !== 16'h5555) begin
               errors++;
               $display("[TB] FAIL hold%0d_q chunk=%0d: got %h, expected 5555", c, CH[i], q[i]);
            end
         end
      end
      in_valid = 1'b0;
      retire();
   endtask

   task automatic test_reset_midcalc();
      in_a     = 16'hFFFF;
      in_b     = 16'hFFFF;
      in_op    = 1'b0;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (ov !== 3'b000 || bz !== 3'b000 || cb !== 3'b000 || ovf !== 3'b000 || zr !== 3'b000 || q !== '0) begin
         errors++;
         $display("[TB] FAIL midcalc_reset: got valid %b busy %b cb %b q %h, expected all zero", ov, bz, cb, q);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      run_op(16'h0001, 16'h0001, 1'b0);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (rq[i] !== 16'h0002 || rcb[i] !== 1'b0 || rovf[i] !== 1'b0 || rzero[i] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL after_reset_add chunk=%0d: got q %h cb %b ovf %b zero %b, expected 0002 0 0 0",
                     CH[i], rq[i], rcb[i], rovf[i], rzero[i]);
         end
      end
      retire();
   endtask

   task automatic test_random();
      logic [WIDTH-1:0] a, b, eq;
      logic [31:0]      rv;
      logic             op, ecb, eovf;
      int               sa, sb, r, ua, ub;
      for (int n = 0; n < 100; n++) begin
         a  = WIDTH'($urandom);
         b  = WIDTH'($urandom);
         op = 1'($urandom);
         sa = int'($signed(a));
         sb = int'($signed(b));
         ua = int'({16'h0000, a});
         ub = int'({16'h0000, b});
         r  = op ? sa - sb : sa + sb;
         rv = r;
         eovf = (r > 32767) || (r < -32768);
         ecb  = op ? (ua < ub) : (ua + ub > 65535);
         eq   = rv[WIDTH-1:0];
         if (SAT && eovf) eq = (r > 0) ? 16'h7FFF : 16'h8000;
         run_op(a, b, op);
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (rq[i] !== eq || rcb[i] !== ecb || rovf[i] !== eovf || rzero[i] !== (eq == '0) ||
                rlat[i] != WIDTH / CH[i]) begin
               errors++;
               $display("[TB] FAIL rand%0d chunk=%0d (%h op%0d %h): got q %h cb %b ovf %b zero %b lat %0d, expected %h %b %b %b %0d",
                        n, CH[i], a, op, b, rq[i], rcb[i], rovf[i], rzero[i], rlat[i],
                        eq, ecb, eovf, (eq == '0), WIDTH / CH[i]);
            end
         end
         retire();
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_midcalc();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
